chip_burst_driver: RTL and testbench
====================================

Name: chip_burst_driver

Overview:
- Initiator-side engine for the per-bank `Chip` array interface: takes one burst request (bank group, bank, row, start column, read/write, write data) over a valid/ready handshake.
- Drives the addressed bank's rd_o_wr/row/column/dqin for BL consecutive cycles and captures dqout for reads.
- Returns the assembled read burst over a valid/ready response. Sits between the command scheduler and the `Chip` model.

Parameters:
- BGWIDTH, 2, bank-group select width (BANKGROUPS = 2**BGWIDTH)
- BAWIDTH, 2, bank select width (BANKSPERGROUP = 2**BAWIDTH)
- COLWIDTH, 10, column address width
- CHWIDTH, 5, row address width
- DEVICE_WIDTH, 4, data bits per beat
- BL, 8, burst length; power of 2, 2..COLS
- RDLAT, 1, cycles from column presented to valid dqout

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- req_valid  input  1  request valid
- req_ready  output  1  engine can accept a request
- req_wr  input  1  1 = write burst, 0 = read burst
- req_bg  input  BGWIDTH  bank group
- req_ba  input  BAWIDTH  bank within group
- req_row  input  CHWIDTH  row
- req_col  input  COLWIDTH  start column
- req_wdata  input  BL*DEVICE_WIDTH  write burst; beat k = bits [k*DEVICE_WIDTH +: DEVICE_WIDTH]
- wr_done  output  1  one-cycle pulse when the last write beat has been driven
- rsp_valid  output  1  read burst available
- rsp_ready  input  1  consumer accepts read burst
- rsp_rdata  output  BL*DEVICE_WIDTH  read burst, same beat packing as req_wdata
- rd_o_wr  output  1 per [BANKGROUPS][BANKSPERGROUP]  to Chip
- dqin  output  DEVICE_WIDTH per [BANKGROUPS][BANKSPERGROUP]  to Chip
- row  output  CHWIDTH per [BANKGROUPS][BANKSPERGROUP]  to Chip
- column  output  COLWIDTH per [BANKGROUPS][BANKSPERGROUP]  to Chip
- dqout  input  DEVICE_WIDTH per [BANKGROUPS][BANKSPERGROUP]  from Chip

Behaviour:
- Reset (rst_n low at clk edge):
  - state IDLE; req_ready=1; wr_done=0; rsp_valid=0; rsp_rdata=0.
  - All bank outputs 0. Beat and latency counters 0.
  - Reset mid-burst aborts immediately. Bank outputs are 0 from the next cycle and no wr_done/rsp is produced.
- Idle drive: every bank not currently addressed has rd_o_wr, row, column and dqin held at 0, registered.
- State IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch all req_* fields, beat=0, go to BURST.
- State BURST, lasting exactly BL cycles, beat = 0..BL-1. Outputs are registered, so beat 0 appears the cycle after acceptance.
  - Addressed bank: row=latched row; rd_o_wr=req_wr.
  - column = {col[COLWIDTH-1:log2(BL)], (col[log2(BL)-1:0] + beat) mod BL}. The burst wraps inside its BL-aligned block and never touches the next block.
  - dqin = beat k of wdata on writes, 0 on reads.
  - req_ready=0.
- Leaving BURST:
  - Write: outputs return to 0 the cycle after the last beat. wr_done pulses on that cycle. Go to IDLE.
  - Read: go to DRAIN.
- Read capture:
  - dqout of the addressed bank is sampled RDLAT cycles after each column appears on the interface.
  - The sample is stored in rsp_rdata beat slot k, where k is the beat index, not the wrapped column.
  - DRAIN lasts until the last beat is captured (RDLAT cycles).
  - The beat-0 capture overlaps BURST when RDLAT < BL.
- State RESP:
  - rsp_valid=1, rsp_rdata stable.
  - On rsp_ready go to IDLE (rsp_valid=0 next cycle).
  - req_ready=0 throughout RESP, so there is no new request until the response is consumed.
- Back-to-back: a new request is accepted in the IDLE cycle after wr_done or after the rsp handshake, so there is a minimum one idle cycle between bursts.
- Simultaneous events:
  - req_valid while not ready: ignored; the requester must hold it.
  - rsp_ready without rsp_valid: ignored.
- Latency:
  - Write accept to wr_done = BL+1 cycles.
  - Read accept to rsp_valid = BL+RDLAT+1 cycles.

Test Plan:
- Write then read, bg=1 ba=1 row=1 col=0, wdata beats 0..7 random: write drives bank[1][1] columns 0..7 with rd_o_wr=1 for 8 cycles, wr_done at accept+9. Read returns rsp_rdata equal to the written data; all other banks stay 0 throughout.
- Wrap: write 0x0..0x7 at col=0, then read with col=5: columns driven 5,6,7,0,1,2,3,4; rsp beats = 0x5,0x6,0x7,0x0,0x1,0x2,0x3,0x4.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid: rsp_valid and rsp_rdata stay stable and req_ready=0. After rsp_ready=1 for one cycle, rsp_valid drops and req_ready=1 on the next cycle.
- Reset mid-burst: drop rst_n at beat 3 of a write to bank[2][3]: from the next cycle all bank outputs are 0, req_ready=1, and wr_done never pulses. A subsequent read of col 0..2 returns the 3 beats already written.
- Isolation: write bank[0][0] with 0xA in every beat and bank[3][3] with 0x5 in every beat, same row and col: reading each returns its own pattern.
- Request held during a burst: req_valid held high with a second request: the second request is accepted only in the first IDLE cycle after completion, and the first burst's outputs are unaffected.

Source files
------------

// File: rtl/chip_burst_driver.sv
// chip_burst_driver: drives one addressed bank of a per-bank Chip array for BL beats
// and assembles read beats into a single valid/ready response.
module chip_burst_driver #(
   parameter int BGWIDTH      = 2,
   parameter int BAWIDTH      = 2,
   parameter int COLWIDTH     = 10,
   parameter int CHWIDTH      = 5,
   parameter int DEVICE_WIDTH = 4,
   parameter int BL           = 8,
   parameter int RDLAT        = 1
) (
   input  logic                                                         clk,
   input  logic                                                         rst_n,
   input  logic                                                         req_valid,
   output logic                                                         req_ready,
   input  logic                                                         req_wr,
   input  logic [BGWIDTH-1:0]                                           req_bg,
   input  logic [BAWIDTH-1:0]                                           req_ba,
   input  logic [CHWIDTH-1:0]                                           req_row,
   input  logic [COLWIDTH-1:0]                                          req_col,
   input  logic [BL*DEVICE_WIDTH-1:0]                                   req_wdata,
   output logic                                                         wr_done,
   output logic                                                         rsp_valid,
   input  logic                                                         rsp_ready,
   output logic [BL*DEVICE_WIDTH-1:0]                                   rsp_rdata,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                        rd_o_wr,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0]      dqin,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]           row,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][COLWIDTH-1:0]          column,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0]      dqout
);
   localparam int BW = $clog2(BL);
   localparam logic [COLWIDTH-1:0] BMASK = COLWIDTH'(BL - 1);
   typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESP} state_t;
   state_t                                                       state_q;
   logic [BW-1:0]                                                beat_q, beat_d, cap_q;
   logic [RDLAT-1:0]                                             pipe_q;
   logic                                                         wr_q, wr_d, drive_d;
   logic                                                         req_ready_q, wr_done_q, rsp_valid_q;
   logic [BGWIDTH-1:0]                                           bg_q, bg_d;
   logic [BAWIDTH-1:0]                                           ba_q, ba_d;
   logic [CHWIDTH-1:0]                                           lrow_q, lrow_d;
   logic [COLWIDTH-1:0]                                          col_q, col_d;
   logic [BL*DEVICE_WIDTH-1:0]                                   wdata_q, wdata_d, rdata_q;
   logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                        rd_o_wr_q;
   logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0]      dqin_q;
   logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]           row_q;
   logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][COLWIDTH-1:0]          column_q;
   // Beat 0 comes straight from the request fields on acceptance, later beats from the latch.
   always_comb begin
      drive_d = (state_q == IDLE && req_valid) || (state_q == BURST && beat_q != BW'(BL - 1));
      beat_d  = state_q == IDLE ? '0 : beat_q + 1'b1;
      wr_d    = state_q == IDLE ? req_wr : wr_q;
      bg_d    = state_q == IDLE ? req_bg : bg_q;
      ba_d    = state_q == IDLE ? req_ba : ba_q;
      lrow_d  = state_q == IDLE ? req_row : lrow_q;
      col_d   = state_q == IDLE ? req_col : col_q;
      wdata_d = state_q == IDLE ? req_wdata : wdata_q;
   end
   always_ff @(posedge clk) begin
      rd_o_wr_q <= '0;
      dqin_q    <= '0;
      row_q     <= '0;
      column_q  <= '0;
      wr_done_q <= 1'b0;
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         beat_q      <= '0;
         cap_q       <= '0;
         pipe_q      <= '0;
         wr_q        <= 1'b0;
         bg_q        <= '0;
         ba_q        <= '0;
         lrow_q      <= '0;
         col_q       <= '0;
         wdata_q     <= '0;
      end else begin
         pipe_q <= RDLAT'({pipe_q, state_q == BURST && !wr_q});
         if (drive_d) begin
            beat_q                 <= beat_d;
            rd_o_wr_q[bg_d][ba_d]  <= wr_d;
            row_q[bg_d][ba_d]      <= lrow_d;
            column_q[bg_d][ba_d]   <= (col_d & ~BMASK) | ((col_d + COLWIDTH'(beat_d)) & BMASK);
            dqin_q[bg_d][ba_d]     <= wr_d ? wdata_d[beat_d*DEVICE_WIDTH +: DEVICE_WIDTH] : '0;
         end
         // Captures arrive in beat order, so a counter gives the slot regardless of wrap.
         if (pipe_q[RDLAT-1]) begin
            rdata_q[cap_q*DEVICE_WIDTH +: DEVICE_WIDTH] <= dqout[bg_q][ba_q];
            cap_q <= cap_q + 1'b1;
         end
         case (state_q)
            IDLE: if (req_valid) begin
               state_q     <= BURST;
               req_ready_q <= 1'b0;
               cap_q       <= '0;
               wr_q        <= req_wr;
               bg_q        <= req_bg;
               ba_q        <= req_ba;
               lrow_q      <= req_row;
               col_q       <= req_col;
               wdata_q     <= req_wdata;
            end
            BURST: if (beat_q == BW'(BL - 1)) begin
               state_q     <= wr_q ? IDLE : DRAIN;
               wr_done_q   <= wr_q;
               req_ready_q <= wr_q;
            end
            DRAIN: if (pipe_q[RDLAT-1] && cap_q == BW'(BL - 1)) begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
            end
            RESP: if (rsp_ready) begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign req_ready = req_ready_q;
   assign wr_done   = wr_done_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rd_o_wr   = rd_o_wr_q;
   assign dqin      = dqin_q;
   assign row       = row_q;
   assign column    = column_q;
endmodule

// File: tb/tb_chip_burst_driver.sv
// tb_chip_burst_driver: randomized scoreboard bench with a behavioural Chip memory and
// a burst-level reference model of expected bank drive, wr_done and read responses.
module tb_chip_burst_driver;
   localparam int BL = 8, DW = 4, RDLAT = 1, NB = 4;
   typedef struct {int bg; int ba; int wr; int row; int col; int dq;} drv_t;
   typedef struct {int cyc; logic [31:0] data;} rsp_t;
   logic clk = 0, rst_n = 0;
   logic req_valid = 0, req_wr = 0, rsp_ready = 0;
   logic req_ready, wr_done, rsp_valid;
   logic [1:0] req_bg = 0, req_ba = 0;
   logic [4:0] req_row = 0;
   logic [9:0] req_col = 0;
   logic [31:0] req_wdata = 0, rsp_rdata;
   logic [3:0][3:0] rd_o_wr;
   logic [3:0][3:0][3:0] dqin, dqout;
   logic [3:0][3:0][4:0] row;
   logic [3:0][3:0][9:0] column;
   int checks = 0, failures = 0, cyc = 0, rdy_from = 0, n_acc = 0, rdy_delay = 0;
   bit chk_en = 0, pv = 0, phs = 0;
   int acc_cyc[$];
   int wq[$];
   rsp_t rq[$];
   drv_t exp_drv[int];
   bit [3:0] ref_mem[int];
   bit [3:0] cmem[int];
   logic [31:0] held = 0, last_rsp = 0;

   chip_burst_driver dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
      .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rd_o_wr(rd_o_wr), .dqin(dqin), .row(row), .column(column), .dqout(dqout)
   );

   always #5 clk = ~clk;

   function automatic int key(input int g, input int b, input int r, input int c);
      return ((g * NB + b) * 32 + r) * 1024 + c;
   endfunction

   function automatic int wrapc(input int c, input int k);
      return (c & ~(BL - 1)) | ((c + k) % BL);
   endfunction

   function automatic bit [3:0] rd_ref(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : 4'h0;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Chip: samples bank inputs mid-cycle, commits writes and presents dqout one cycle later.
   initial begin
      bit w[NB][NB];
      int a[NB][NB];
      logic [3:0] d[NB][NB];
      dqout = '0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NB; g++)
            for (int b = 0; b < NB; b++) begin
               w[g][b] = rd_o_wr[g][b];
               a[g][b] = key(g, b, int'(row[g][b]), int'(column[g][b]));
               d[g][b] = dqin[g][b];
            end
         @(posedge clk);
         #1;
         for (int g = 0; g < NB; g++)
            for (int b = 0; b < NB; b++) begin
               if (w[g][b]) cmem[a[g][b]] = d[g][b];
               dqout[g][b] = cmem.exists(a[g][b]) ? cmem[a[g][b]] : 4'h0;
            end
      end
   end

   initial begin
      int vc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            rsp_ready = (vc >= rdy_delay);
            vc++;
         end else begin
            vc = 0;
            rsp_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: compares every cycle against the model, then records any acceptance.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin : mon
         drv_t e;
         rsp_t r;
         bit has, bad;
         logic [19:0] av, ev, ma, me;
         logic [31:0] d;
         has = exp_drv.exists(cyc);
         if (has) e = exp_drv[cyc];
         bad = 0; ma = 0; me = 0;
         for (int g = 0; g < NB; g++)
            for (int b = 0; b < NB; b++) begin
               av = {rd_o_wr[g][b], row[g][b], column[g][b], dqin[g][b]};
               ev = (has && e.bg == g && e.ba == b) ? {e.wr[0], e.row[4:0], e.col[9:0], e.dq[3:0]} : 20'h0;
               if (av !== ev && !bad) begin
                  bad = 1; ma = av; me = ev;
               end
            end
         chk("bank_drive", ma, me);
         if (has && e.wr != 0) ref_mem[key(e.bg, e.ba, e.row, e.col)] = e.dq[3:0];
         if (has) exp_drv.delete(cyc);
         chk("req_ready", req_ready, cyc >= rdy_from);
         if (wr_done) begin
            if (wq.size() == 0) chk("wr_done_spurious", wr_done, 0);
            else chk("wr_done_cycle", cyc, wq.pop_front());
         end else if (wq.size() != 0 && wq[0] == cyc) begin
            chk("wr_done_missing", wr_done, 1);
            void'(wq.pop_front());
         end
         if (rsp_valid && !pv) begin
            if (rq.size() == 0) chk("rsp_spurious", rsp_valid, 0);
            else begin
               r = rq.pop_front();
               chk("rsp_cycle", cyc, r.cyc);
               chk("rsp_data", rsp_rdata, r.data);
            end
            held = rsp_rdata;
            last_rsp = rsp_rdata;
         end else if (rsp_valid) chk("rsp_stable", rsp_rdata, held);
         else if (rq.size() != 0 && rq[0].cyc == cyc) begin
            chk("rsp_missing", rsp_valid, 1);
            void'(rq.pop_front());
         end
         if (phs) chk("rsp_drop", rsp_valid, 0);
         if (rsp_valid && rsp_ready) rdy_from = cyc + 1;
         pv = rsp_valid;
         phs = rsp_valid && rsp_ready;
         if (rst_n && req_valid && req_ready) begin
            acc_cyc.push_back(cyc);
            n_acc++;
            for (int k = 0; k < BL; k++) begin
               e.bg = req_bg; e.ba = req_ba; e.wr = req_wr; e.row = req_row;
               e.col = wrapc(req_col, k);
               e.dq = req_wr ? int'(req_wdata[k*DW +: DW]) : 0;
               exp_drv[cyc + 1 + k] = e;
            end
            if (req_wr) begin
               wq.push_back(cyc + BL + 1);
               rdy_from = cyc + BL + 1;
            end else begin
               d = 0;
               for (int k = 0; k < BL; k++)
                  d[k*DW +: DW] = rd_ref(key(req_bg, req_ba, req_row, wrapc(req_col, k)));
               r.cyc = cyc + BL + RDLAT + 1;
               r.data = d;
               rq.push_back(r);
               rdy_from = 1 << 30;
            end
         end
      end
   end

   task automatic do_req(input bit wr, input int bg, input int ba, input int rw, input int col, input logic [31:0] wd);
      int n0 = n_acc;
      int t = 0;
      req_wr = wr; req_bg = 2'(bg); req_ba = 2'(ba); req_row = 5'(rw); req_col = 10'(col);
      req_wdata = wd; req_valid = 1;
      while (n_acc == n0 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("req_accept", n_acc - n0, 1);
      req_valid = 0;
   endtask

   task automatic wait_done();
      int t = 0;
      while ((rq.size() != 0 || wq.size() != 0 || cyc < rdy_from) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", t < 200, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] wd;
      int n0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1; chk_en = 1; rdy_from = 0;
      @(negedge clk);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_wr_done", wr_done, 0);
      @(posedge clk);
      #1;
      wd = $urandom;
      do_req(1, 1, 1, 1, 0, wd);
      do_req(0, 1, 1, 1, 0, 0);
      wait_done();
      chk("wr_rd_data", last_rsp, wd);
      do_req(1, 0, 2, 2, 0, 32'h76543210);
      do_req(0, 0, 2, 2, 5, 0);
      wait_done();
      chk("wrap_data", last_rsp, 32'h43210765);
      rdy_delay = 10;
      do_req(0, 1, 1, 1, 0, 0);
      wait_done();
      chk("backpressure_data", last_rsp, wd);
      rdy_delay = 0;
      wd = $urandom;
      do_req(1, 2, 3, 4, 0, wd);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 0;
      for (int k = 1; k <= BL; k++) exp_drv.delete(cyc + k);
      wq.delete();
      rq.delete();
      rdy_from = cyc + 1;
      @(posedge clk);
      #1;
      rst_n = 1;
      do_req(0, 2, 3, 4, 0, 0);
      wait_done();
      chk("reset_partial_data", last_rsp[11:0], wd[11:0]);
      do_req(1, 0, 0, 3, 8, 32'hAAAAAAAA);
      do_req(1, 3, 3, 3, 8, 32'h55555555);
      do_req(0, 0, 0, 3, 8, 0);
      wait_done();
      chk("isolation_00", last_rsp, 32'hAAAAAAAA);
      do_req(0, 3, 3, 3, 8, 0);
      wait_done();
      chk("isolation_33", last_rsp, 32'h55555555);
      n0 = n_acc;
      do_req(1, 1, 2, 0, 16, $urandom);
      do_req(1, 2, 1, 0, 16, $urandom);
      wait_done();
      chk("held_write_gap", acc_cyc[n0+1] - acc_cyc[n0], BL + 1);
      n0 = n_acc;
      do_req(0, 1, 2, 0, 16, 0);
      do_req(0, 2, 1, 0, 16, 0);
      wait_done();
      chk("held_read_gap", acc_cyc[n0+1] - acc_cyc[n0], BL + RDLAT + 2);
      for (int i = 0; i < 24; i++) begin
         rdy_delay = $urandom_range(0, 3);
         do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 31), $urandom);
      end
      wait_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
